// File: rtl/peripheral_spram_pkg.sv
// Shared definitions for the multi-channel single-port SRAM peripheral:
// geometry helpers and the response tag carried down the read-return pipeline.
package peripheral_spram_pkg;

    localparam int MAX_CHANNELS = 8;
    localparam int CH_IDX_W     = 3;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int word_idx_width(input int addr_width, input int data_width);
        return addr_width - word_lsb(data_width);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] ch;
        logic                err;
        logic                we;
    } resp_tag_t;

endpackage

// File: rtl/peripheral_spram_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the
// priority pointer wins; the caller owns and advances the pointer.
module peripheral_spram_rr_arbiter #(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    input  logic                advance_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [IDX_W-1:0]    idx_o
);

    logic found;

    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            c = (int'(ptr_i) + i) % CHANNELS;
            if (advance_i && !found && req_i[c]) begin
                gnt_o[c] = 1'b1;
                idx_o    = IDX_W'(c);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_spram_mc.sv
// Multi-channel single-port SRAM: round-robin arbitration of CHANNELS request
// ports onto one byte-enabled array, with a tagged in-order response pipeline.
module peripheral_spram_mc
    import peripheral_spram_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [CHANNELS-1:0]              req_i,
    input  logic [CHANNELS-1:0]              we_i,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [CHANNELS*DATA_WIDTH/8-1:0] be_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   data_i,
    output logic [CHANNELS-1:0]              gnt_o,
    output logic [CHANNELS-1:0]              rvalid_o,
    output logic [CHANNELS-1:0]              err_o,
    output logic [CHANNELS*DATA_WIDTH-1:0]   data_o
);

    localparam int LANES  = lane_count(DATA_WIDTH);
    localparam int LSB    = word_lsb(DATA_WIDTH);
    localparam int WIDX_W = word_idx_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  acc;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LANES-1:0]      sel_be;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [WIDX_W-1:0]     word_idx;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  in_range;
    logic [LANES-1:0]      wr_lane;

    peripheral_spram_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr),
        .advance_i (1'b1),
        .gnt_o     (gnt_o),
        .idx_o     (gnt_idx)
    );

    assign acc      = |gnt_o;
    assign sel_we   = we_i[gnt_idx];
    assign sel_addr = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_be   = be_i[int'(gnt_idx)*LANES +: LANES];
    assign sel_data = data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign word_idx = sel_addr[ADDR_WIDTH-1:LSB];
    assign mem_addr = word_idx[MEM_AW-1:0];
    assign in_range = (64'(word_idx) < 64'(DEPTH));
    assign wr_lane  = {LANES{acc && sel_we && in_range}} & sel_be;

    // Sub-word address bits only select bytes within a word and are ignored.
    if (LSB > 0) begin : g_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^sel_addr[LSB-1:0];
    end

    // ---- stage p0: array access, tag capture, pointer advance ----
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_p0;
    resp_tag_t             tag_p0;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < LANES; b++) begin
            if (wr_lane[b]) mem[mem_addr][b*8 +: 8] <= sel_data[b*8 +: 8];
        end
        if (acc && !sel_we) rdata_p0 <= in_range ? mem[mem_addr] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_p0 <= '0;
            ptr    <= '0;
        end else begin
            tag_p0.valid <= acc;
            tag_p0.ch    <= CH_IDX_W'(gnt_idx);
            tag_p0.err   <= !in_range;
            tag_p0.we    <= sel_we;
            if (acc) ptr <= (gnt_idx == IDX_W'(CHANNELS-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---- stage p1: optional output register for the two-cycle latency ----
    resp_tag_t             tag_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    if (READ_LATENCY == 2) begin : g_lat2
        resp_tag_t             tag_p1;
        logic [DATA_WIDTH-1:0] rdata_p1;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) tag_p1 <= '0;
            else         tag_p1 <= tag_p0;
        end

        always_ff @(posedge clk_i) rdata_p1 <= rdata_p0;

        assign tag_q   = tag_p1;
        assign rdata_q = rdata_p1;
    end else begin : g_lat1
        assign tag_q   = tag_p0;
        assign rdata_q = rdata_p0;
    end

    // ---- response fan-out: per-channel strobe, error and held read data ----
    logic [DATA_WIDTH-1:0] hold_q [CHANNELS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) hold_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (tag_q.valid && !tag_q.we && tag_q.ch == CH_IDX_W'(c)) hold_q[c] <= rdata_q;
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        data_o   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rvalid_o[c] = tag_q.valid && (tag_q.ch == CH_IDX_W'(c));
            err_o[c]    = rvalid_o[c] && tag_q.err;
            data_o[c*DATA_WIDTH +: DATA_WIDTH] = rvalid_o[c] ? (tag_q.we ? '0 : rdata_q) : hold_q[c];
        end
    end

endmodule

// File: tb/tb_peripheral_spram_mc.sv
// Directed bench: two 4-channel instances (read latency 1 and 2) share one
// stimulus stream; single-channel vectors come from a table, corner cases are hand-written.
module tb_peripheral_spram_mc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   req, we;
    logic [63:0]  addr;
    logic [31:0]  be;
    logic [255:0] wdata;
    logic [3:0]   gnt1, rv1, err1, gnt2, rv2, err2;
    logic [255:0] rd1, rd2;

    int checks = 0;
    int errors = 0;

    peripheral_spram_mc #(
        .CHANNELS(4), .ADDR_WIDTH(16), .DATA_WIDTH(64), .DEPTH(1024), .READ_LATENCY(1)
    ) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .data_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .err_o(err1), .data_o(rd1)
    );

    peripheral_spram_mc #(
        .CHANNELS(4), .ADDR_WIDTH(16), .DATA_WIDTH(64), .DEPTH(1024), .READ_LATENCY(2)
    ) u_lat2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .data_i(wdata), .gnt_o(gnt2), .rvalid_o(rv2), .err_o(err2), .data_o(rd2)
    );

    typedef struct {
        int          ch;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic        exp_err;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic drive(input int c, input logic w, input logic [15:0] a,
                         input logic [7:0] b, input logic [63:0] d);
        req[c]            = 1'b1;
        we[c]             = w;
        addr[c*16 +: 16]  = a;
        be[c*8 +: 8]      = b;
        wdata[c*64 +: 64] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] exp_g, exp_1, exp_2;

        tbl[0]  = '{0, 1'b1, 16'h0010, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        tbl[1]  = '{1, 1'b0, 16'h0010, 8'h00, 64'h0,                1'b0, 64'h1122334455667788};
        tbl[2]  = '{2, 1'b1, 16'h0010, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
        tbl[3]  = '{3, 1'b0, 16'h0010, 8'h00, 64'h0,                1'b0, 64'h11223344AAAAAAAA};
        tbl[4]  = '{0, 1'b1, 16'h0000, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h0};
        tbl[5]  = '{1, 1'b0, 16'h2000, 8'h00, 64'h0,                1'b1, 64'h0};
        tbl[6]  = '{2, 1'b1, 16'h2000, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1, 64'h0};
        tbl[7]  = '{3, 1'b0, 16'h0000, 8'h00, 64'h0,                1'b0, 64'h0123456789ABCDEF};
        tbl[8]  = '{0, 1'b0, 16'h0017, 8'h00, 64'h0,                1'b0, 64'h11223344AAAAAAAA};
        tbl[9]  = '{1, 1'b1, 16'h1FF8, 8'hFF, 64'hCAFEF00D12345678, 1'b0, 64'h0};
        tbl[10] = '{2, 1'b0, 16'h1FF8, 8'h00, 64'h0,                1'b0, 64'hCAFEF00D12345678};
        tbl[11] = '{3, 1'b0, 16'hFFF8, 8'h00, 64'h0,                1'b1, 64'h0};

        clear_req();
        step();
        step();
        chk("reset gnt u1", gnt1, 0);
        chk("reset rvalid u1", rv1, 0);
        chk("reset err u1", err1, 0);
        chk("reset data u1", rd1[63:0] | rd1[127:64] | rd1[191:128] | rd1[255:192], 0);
        chk("reset rvalid u2", rv2, 0);
        chk("reset data u2", rd2[63:0] | rd2[127:64] | rd2[191:128] | rd2[255:192], 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            clear_req();
            drive(tbl[i].ch, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].data);
            #1;
            chk($sformatf("row%0d gnt u1", i), gnt1, 64'(4'b1 << tbl[i].ch));
            chk($sformatf("row%0d gnt u2", i), gnt2, 64'(4'b1 << tbl[i].ch));
            step();
            clear_req();
            chk($sformatf("row%0d rvalid u1", i), rv1, 64'(4'b1 << tbl[i].ch));
            chk($sformatf("row%0d err u1", i), err1[tbl[i].ch], tbl[i].exp_err);
            chk($sformatf("row%0d data u1", i), rd1[tbl[i].ch*64 +: 64], tbl[i].exp_data);
            step();
            chk($sformatf("row%0d rvalid u2", i), rv2, 64'(4'b1 << tbl[i].ch));
            chk($sformatf("row%0d err u2", i), err2[tbl[i].ch], tbl[i].exp_err);
            chk($sformatf("row%0d data u2", i), rd2[tbl[i].ch*64 +: 64], tbl[i].exp_data);
            chk($sformatf("row%0d idle u1", i), rv1, 0);
        end

        // All four channels request continuously from a fresh pointer.
        pulse_reset();
        for (int c = 0; c < 4; c++) drive(c, 1'b0, 16'h0000, 8'h00, 64'h0);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) clear_req();
            #1;
            exp_g = (k < 8) ? (4'b1 << (k % 4)) : 4'b0;
            exp_1 = (k >= 1 && k <= 8) ? (4'b1 << ((k - 1) % 4)) : 4'b0;
            exp_2 = (k >= 2 && k <= 9) ? (4'b1 << ((k - 2) % 4)) : 4'b0;
            chk($sformatf("rr%0d gnt u1", k), gnt1, exp_g);
            chk($sformatf("rr%0d gnt u2", k), gnt2, exp_g);
            chk($sformatf("rr%0d rvalid u1", k), rv1, exp_1);
            chk($sformatf("rr%0d rvalid u2", k), rv2, exp_2);
            step();
        end

        // Write in one cycle, read of the same word on another channel the next.
        clear_req();
        drive(0, 1'b1, 16'h0028, 8'hFF, 64'h5555AAAA5555AAAA);
        #1;
        chk("wr-rd gnt ch0", gnt1, 4'b0001);
        step();
        clear_req();
        drive(1, 1'b0, 16'h0028, 8'h00, 64'h0);
        #1;
        chk("wr-rd gnt ch1", gnt1, 4'b0010);
        chk("wr-rd wresp rvalid u1", rv1, 4'b0001);
        chk("wr-rd wresp data u1", rd1[63:0], 64'h0);
        chk("wr-rd wresp err u1", err1, 0);
        step();
        clear_req();
        chk("wr-rd rresp rvalid u1", rv1, 4'b0010);
        chk("wr-rd rresp data u1", rd1[127:64], 64'h5555AAAA5555AAAA);
        chk("wr-rd ch0 hold u1", rd1[63:0], 64'h0123456789ABCDEF);
        chk("wr-rd wresp rvalid u2", rv2, 4'b0001);
        step();
        chk("wr-rd rresp rvalid u2", rv2, 4'b0010);
        chk("wr-rd rresp data u2", rd2[127:64], 64'h5555AAAA5555AAAA);
        chk("wr-rd idle u1", rv1, 0);
        chk("wr-rd held data u1", rd1[127:64], 64'h5555AAAA5555AAAA);

        // Reset pulse with reads in flight.
        drive(1, 1'b0, 16'h0010, 8'h00, 64'h0);
        step();
        clear_req();
        drive(2, 1'b0, 16'h0000, 8'h00, 64'h0);
        #1;
        chk("flight ch1 resp u1", rv1, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        clear_req();
        step();
        chk("flight drop u1 a", rv1, 0);
        chk("flight drop u2 a", rv2, 0);
        chk("flight data cleared u1", rd1[127:64], 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("flight drop u1 b", rv1, 0);
        chk("flight drop u2 b", rv2, 0);
        step();
        chk("flight drop u2 c", rv2, 0);
        for (int c = 0; c < 4; c++) drive(c, 1'b0, 16'h0000, 8'h00, 64'h0);
        #1;
        chk("post-reset gnt u1", gnt1, 4'b0001);
        chk("post-reset gnt u2", gnt2, 4'b0001);
        step();
        clear_req();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
